// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests / exception info in, per-stage
// hold vector, flush redirect and status out.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic [31:0] stall_cnt;
  logic        wdog_trip;

  // Core side: raises requests, consumes stall/flush.
  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    input  stall, flush, new_pc, busy, stall_cnt, wdog_trip
  );

  // Controller side.
  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    output stall, flush, new_pc, busy, stall_cnt, wdog_trip
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage core.
// Merges ID/EX/MEM stall requests into stall[5:0] (bit0 PC .. bit5 WB),
// sequences exception/ERET flushes and counts stalled cycles.
// Optional stall watchdog enabled by defining PIPE_WDOG_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE    = 32'h0000_000e,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          WDOG_LIMIT   = 64
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  hold_cnt;
  logic [31:0] tgt_q;
  logic        busy_q;
  logic [31:0] stall_cnt_q;

  logic        wdog_req;
  logic        exc_hit;
  logic [31:0] exc_tgt;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] npc_c;

  // Redirect source: a real exception, or a watchdog-forced flush.
  assign exc_hit = (bus.excepttype != 32'd0) || wdog_req;
  assign exc_tgt = (bus.excepttype == ERET_CODE) ? bus.cp0_epc : EXC_VECTOR;

  // Zero-latency stall/flush decode; everything held low while in reset.
  always_comb begin
    stall_c = 6'b000000;
    flush_c = 1'b0;
    npc_c   = 32'd0;
    if (!rst) begin
      if (state == FLUSH) begin
        flush_c = 1'b1;
        npc_c   = tgt_q;
      end else if (exc_hit) begin
        flush_c = 1'b1;
        npc_c   = exc_tgt;
      end else if (bus.stallreq_mem) begin
        stall_c = 6'b011111;
      end else if (bus.stallreq_ex) begin
        stall_c = 6'b001111;
      end else if (bus.stallreq_id) begin
        stall_c = 6'b000111;
      end
    end
  end

  // Flush sequencer: latch target, hold flush for FLUSH_CYCLES total.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      hold_cnt <= 3'd0;
      tgt_q    <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (exc_hit) begin
            tgt_q <= exc_tgt;
            if (FLUSH_CYCLES > 1) begin
              state    <= FLUSH;
              hold_cnt <= HOLD_INIT;
              busy_q   <= 1'b1;
            end
          end
        end
        FLUSH: begin
          hold_cnt <= hold_cnt - 3'd1;
          if (hold_cnt == 3'd1) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles with any stage held.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= 32'd0;
    else if ((stall_c != 6'b000000) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

`ifdef PIPE_WDOG_EN
  localparam logic [31:0] WLIM = 32'(WDOG_LIMIT);

  logic [5:0]  prev_stall;
  logic [31:0] wdog_cnt;
  logic [31:0] wdog_nxt;
  logic        wdog_trip_q;

  // Run length including this cycle; a changed vector restarts the run.
  assign wdog_nxt = (stall_c != prev_stall) ? 32'd1 : wdog_cnt + 32'd1;

  // Watchdog: identical nonzero stall for WDOG_LIMIT cycles forces one flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stall  <= 6'b000000;
      wdog_cnt    <= 32'd0;
      wdog_req    <= 1'b0;
      wdog_trip_q <= 1'b0;
    end else begin
      prev_stall <= stall_c;
      wdog_req   <= 1'b0;
      if (stall_c == 6'b000000) begin
        wdog_cnt <= 32'd0;
      end else if (wdog_nxt == WLIM) begin
        wdog_cnt    <= 32'd0;
        wdog_req    <= 1'b1;
        wdog_trip_q <= 1'b1;
      end else begin
        wdog_cnt <= wdog_nxt;
      end
    end
  end

  assign bus.wdog_trip = wdog_trip_q;
`else
  assign wdog_req      = 1'b0;
  assign bus.wdog_trip = 1'b0;
`endif

  assign bus.stall     = stall_c;
  assign bus.flush     = flush_c;
  assign bus.new_pc    = npc_c;
  assign bus.busy      = busy_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_CYCLES=3, WDOG_LIMIT=4).
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.FLUSH_CYCLES(3), .WDOG_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // new_pc is only meaningful while flush is expected high.
  task automatic expect_out(input string tag, input logic [5:0] st, input logic fl,
                            input logic [31:0] pc, input logic by);
    chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
    chk({tag, ".flush"}, 32'(bus.flush), 32'(fl));
    if (fl) chk({tag, ".new_pc"}, bus.new_pc, pc);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(by));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.stallreq_id  = 1'b1;
    bus.stallreq_ex  = 1'b1;
    bus.stallreq_mem = 1'b1;
    bus.excepttype   = 32'd0;
    bus.cp0_epc      = 32'd0;

    // Reset held two cycles with every request raised.
    tick(); #1;
    expect_out("rst1", 6'h00, 1'b0, 32'd0, 1'b0);
    chk("rst1.new_pc", bus.new_pc, 32'd0);
    chk("rst1.cnt", bus.stall_cnt, 32'd0);
    chk("rst1.trip", 32'(bus.wdog_trip), 32'd0);
    tick(); #1;
    expect_out("rst2", 6'h00, 1'b0, 32'd0, 1'b0);

    rst = 1'b0; #1;
    expect_out("allreq", 6'b011111, 1'b0, 32'd0, 1'b0);
    tick(); #1;
    chk("allreq.cnt", bus.stall_cnt, 32'd1);

    // Re-reset to start the count from zero.
    rst = 1'b1;
    bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0;
    tick(); rst = 1'b0; #1;
    chk("rerst.cnt", bus.stall_cnt, 32'd0);

    // ID only for three cycles.
    bus.stallreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 expect_out("id", 6'b000111, 1'b0, 32'd0, 1'b0);
      tick();
    end
    bus.stallreq_id = 1'b0; #1;
    expect_out("id.off", 6'h00, 1'b0, 32'd0, 1'b0);
    chk("id.cnt", bus.stall_cnt, 32'd3);

    // ID+EX, then drop EX.
    bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1; #1;
    expect_out("idex", 6'b001111, 1'b0, 32'd0, 1'b0);
    tick(); bus.stallreq_ex = 1'b0; #1;
    expect_out("id2", 6'b000111, 1'b0, 32'd0, 1'b0);
    tick(); bus.stallreq_id = 1'b0; #1;
    chk("idex.cnt", bus.stall_cnt, 32'd5);

    // Exception with MEM stall: exception wins, flush held 3 cycles to EXC_VECTOR.
    bus.excepttype = 32'h8; bus.stallreq_mem = 1'b1; #1;
    expect_out("exc.c1", 6'h00, 1'b1, 32'h20, 1'b0);
    tick(); bus.excepttype = 32'he; bus.cp0_epc = 32'h1000; #1;
    expect_out("exc.c2", 6'h00, 1'b1, 32'h20, 1'b1);
    tick(); #1;
    expect_out("exc.c3", 6'h00, 1'b1, 32'h20, 1'b1);
    tick(); bus.excepttype = 32'd0; bus.stallreq_mem = 1'b0; #1;
    expect_out("exc.end", 6'h00, 1'b0, 32'd0, 1'b0);
    chk("exc.cnt", bus.stall_cnt, 32'd5);

    // ERET: target is EPC, latched even if inputs change.
    bus.excepttype = 32'he; bus.cp0_epc = 32'h1000; #1;
    expect_out("eret.c1", 6'h00, 1'b1, 32'h1000, 1'b0);
    tick(); bus.excepttype = 32'h8; bus.cp0_epc = 32'h2000; #1;
    expect_out("eret.c2", 6'h00, 1'b1, 32'h1000, 1'b1);
    tick(); bus.excepttype = 32'd0; #1;
    expect_out("eret.c3", 6'h00, 1'b1, 32'h1000, 1'b1);
    tick(); #1;
    expect_out("eret.end", 6'h00, 1'b0, 32'd0, 1'b0);

    // MEM only.
    bus.stallreq_mem = 1'b1; #1;
    expect_out("mem", 6'b011111, 1'b0, 32'd0, 1'b0);
    tick(); bus.stallreq_mem = 1'b0; #1;
    chk("mem.cnt", bus.stall_cnt, 32'd6);

    // Reset in the middle of a flush sequence.
    bus.excepttype = 32'h8; #1;
    chk("mid.flush", 32'(bus.flush), 32'd1);
    tick(); bus.excepttype = 32'd0; rst = 1'b1; #1;
    chk("mid.rst.flush", 32'(bus.flush), 32'd0);
    tick(); rst = 1'b0; #1;
    expect_out("mid.after", 6'h00, 1'b0, 32'd0, 1'b0);
    chk("mid.cnt", bus.stall_cnt, 32'd0);

    // Watchdog: EX held.
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 expect_out("wd.stall", 6'b001111, 1'b0, 32'd0, 1'b0);
      chk("wd.pre.trip", 32'(bus.wdog_trip), 32'd0);
      tick();
    end
    #1;
`ifdef PIPE_WDOG_EN
    chk("wd.trip", 32'(bus.wdog_trip), 32'd1);
    expect_out("wd.f1", 6'h00, 1'b1, 32'h20, 1'b0);
    tick(); #1;
    expect_out("wd.f2", 6'h00, 1'b1, 32'h20, 1'b1);
    tick(); #1;
    expect_out("wd.f3", 6'h00, 1'b1, 32'h20, 1'b1);
    tick(); bus.stallreq_ex = 1'b0; #1;
    expect_out("wd.end", 6'h00, 1'b0, 32'd0, 1'b0);
    chk("wd.sticky", 32'(bus.wdog_trip), 32'd1);
    chk("wd.cnt", bus.stall_cnt, 32'd4);
`else
    chk("wd.notrip", 32'(bus.wdog_trip), 32'd0);
    expect_out("wd.nf", 6'b001111, 1'b0, 32'd0, 1'b0);
    tick(); bus.stallreq_ex = 1'b0; #1;
    chk("wd.notrip2", 32'(bus.wdog_trip), 32'd0);
    chk("wd.cnt", bus.stall_cnt, 32'd5);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
